// File: rtl/wave_mux_generator.sv
// wave_mux_generator
//   Phase-accumulator waveform generator with a glitch-free selection switch.
//   A new waveform selection is only taken at a phase wrap, so the output
//   never jumps mid-period. If phase_inc is 0, the accumulator never wraps,
//   so the switch is taken on the next tick instead.
//
// Ports
//   clk          : single clock, all state on the rising edge
//   reset        : asynchronous, active-high
//   sel_in       : [7] enable, [3] invert, [2:0] wave type (0..4), [6:4] ignored
//   phase_inc    : per-tick phase increment
//   sample_tick  : one-cycle sample-rate strobe
//   sample_out   : registered sample, unsigned offset-binary
//   sample_valid : one-cycle pulse, sample_out updated this cycle
//   active_sel   : {invert, type} currently generating
//   wrap         : one-cycle pulse on accumulator carry-out
//   busy_pending : high while a selection change waits for a phase wrap
//   dbg_state    : current FSM state (0 idle, 1 run, 2 pending)
//
// Handshake: there is no backpressure. Every sample_tick produces
// sample_valid exactly one cycle later, and the consumer must take the
// sample in that cycle.
module wave_mux_generator #(
    parameter int ACC_W = 24,
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       sel_in,
    input  logic [ACC_W-1:0] phase_inc,
    input  logic             sample_tick,
    output logic [OUT_W-1:0] sample_out,
    output logic             sample_valid,
    output logic [3:0]       active_sel,
    output logic             wrap,
    output logic             busy_pending,
    output logic [1:0]       dbg_state
);

    localparam logic [OUT_W-1:0] MIDSCALE = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;

    logic             w_sel_valid;
    logic [3:0]       w_sel_code;
    logic             w_sel_differs;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_carry;
    logic             w_switch_now;
    logic [OUT_W-1:0] w_phase;
    logic [OUT_W-1:0] w_tri_raw;
    logic [OUT_W-1:0] w_wave;
    logic [OUT_W-1:0] w_sample;
    logic             w_unused_sel;

    assign w_sel_valid   = sel_in[7] && (sel_in[2:0] <= 3'd4);
    assign w_sel_code    = {sel_in[3], sel_in[2:0]};
    assign w_sel_differs = (w_sel_code != active_sel);
    assign w_unused_sel  = ^sel_in[6:4];

    // Extra top bit captures the carry-out that defines a phase wrap.
    assign w_sum      = {1'b0, r_acc} + {1'b0, phase_inc};
    assign w_acc_next = w_sum[ACC_W-1:0];
    assign w_carry    = w_sum[ACC_W];

    // A zero increment never wraps, so a pending switch is taken on any tick.
    assign w_switch_now = sample_tick && (w_carry || (phase_inc == '0));

    // Samples are derived from the post-update accumulator value.
    assign w_phase   = w_acc_next[ACC_W-1 -: OUT_W];
    assign w_tri_raw = w_acc_next[ACC_W-2 -: OUT_W];

    assign dbg_state = r_state;

    always_comb begin
        w_wave = MIDSCALE;
        case (active_sel[2:0])
            3'd0:    w_wave = w_acc_next[ACC_W-1] ? '1 : '0;
            3'd1:    w_wave = w_phase;
            3'd2:    w_wave = w_acc_next[ACC_W-1] ? ~w_tri_raw : w_tri_raw;
            3'd3:    w_wave = ~w_phase;
            default: w_wave = MIDSCALE;
        endcase
    end

    // The sample always uses the selection that is active before this edge.
    // A sel_in change on the same cycle therefore affects later ticks only.
    always_comb begin
        w_sample = MIDSCALE;
        if (r_state != ST_IDLE) begin
            w_sample = active_sel[3] ? ~w_wave : w_wave;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_acc        <= '0;
            sample_out   <= MIDSCALE;
            sample_valid <= 1'b0;
            wrap         <= 1'b0;
            active_sel   <= 4'd0;
            busy_pending <= 1'b0;
        end else begin
            sample_valid <= sample_tick;
            wrap         <= 1'b0;
            if (sample_tick) begin
                sample_out <= w_sample;
            end
            if (sample_tick && (r_state != ST_IDLE)) begin
                r_acc <= w_acc_next;
                wrap  <= w_carry;
            end

            // An invalid selection wins over every other transition.
            if (!w_sel_valid) begin
                r_state      <= ST_IDLE;
                r_acc        <= '0;
                busy_pending <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state      <= ST_RUN;
                        r_acc        <= '0;
                        active_sel   <= w_sel_code;
                        busy_pending <= 1'b0;
                    end
                    ST_RUN: begin
                        if (w_sel_differs) begin
                            r_state      <= ST_PENDING;
                            busy_pending <= 1'b1;
                        end
                    end
                    ST_PENDING: begin
                        if (!w_sel_differs) begin
                            // Request withdrawn before the wrap, so nothing changes.
                            r_state      <= ST_RUN;
                            busy_pending <= 1'b0;
                        end else if (w_switch_now) begin
                            // The accumulator keeps running; only the selection changes.
                            r_state      <= ST_RUN;
                            active_sel   <= w_sel_code;
                            busy_pending <= 1'b0;
                        end
                    end
                    default: begin
                        r_state      <= ST_IDLE;
                        r_acc        <= '0;
                        busy_pending <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wave_mux_generator.sv
// tb_wave_mux_generator
//   Table of single-shot waveform vectors (every wave type and invert mode,
//   starting from a fresh reset) plus hand-written sequences for pending
//   switches, switch cancellation, disable, zero increment and a mid-cycle
//   reset pulse. Expected samples are queued when a tick is driven and
//   popped when sample_valid appears.
module tb_wave_mux_generator;

    logic        clk;
    logic        reset;
    logic [7:0]  sel_in;
    logic [23:0] phase_inc;
    logic        sample_tick;
    logic [11:0] sample_out;
    logic        sample_valid;
    logic [3:0]  active_sel;
    logic        wrap;
    logic        busy_pending;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    // Bit 12 set marks an entry whose sample value is not compared.
    logic [12:0] exp_q[$];

    typedef struct packed {
        logic [7:0]  sel;
        logic [11:0] e1;
        logic [11:0] e2;
        logic [11:0] e3;
        logic [11:0] e4;
    } vec_t;

    vec_t vecs[9];

    wave_mux_generator #(.ACC_W(24), .OUT_W(12)) dut (
        .clk          (clk),
        .reset        (reset),
        .sel_in       (sel_in),
        .phase_inc    (phase_inc),
        .sample_tick  (sample_tick),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .active_sel   (active_sel),
        .wrap         (wrap),
        .busy_pending (busy_pending),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- checker / driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle, optionally with a sample tick. Outputs are sampled
    // 1 time unit after the rising edge.
    task automatic step(input logic tick, input logic [11:0] exp_s,
                        input logic exp_wrap, input logic care);
        logic [12:0] e;
        @(negedge clk);
        sample_tick = tick;
        if (tick) exp_q.push_back({~care, exp_s});
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        check("sample_valid", {31'd0, sample_valid}, {31'd0, tick});
        check("wrap", {31'd0, wrap}, {31'd0, exp_wrap});
        if (sample_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sample_unexpected: got 0x%0h expected no sample", sample_out);
            end else begin
                e = exp_q.pop_front();
                if (!e[12]) check("sample_out", {20'd0, sample_out}, {20'd0, e[11:0]});
            end
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_sample_out", {20'd0, sample_out}, 32'h800);
        check("rst_sample_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_wrap", {31'd0, wrap}, 32'd0);
        check("rst_active_sel", {28'd0, active_sel}, 32'd0);
        check("rst_busy_pending", {31'd0, busy_pending}, 32'd0);
    endtask

    // Reset pulse between edges, then one cycle to enter RUN on sel.
    task automatic start_fresh(input logic [7:0] sel, input logic [23:0] inc);
        sel_in      = sel;
        phase_inc   = inc;
        sample_tick = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        step(1'b0, 12'h000, 1'b0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [11:0] ex[4];

        // Expected samples for inc=0x500000: acc 0x500000, 0xA00000, 0xF00000, 0x400000 (wrap).
        vecs[0] = '{8'h80, 12'h000, 12'hFFF, 12'hFFF, 12'h000};
        vecs[1] = '{8'h81, 12'h500, 12'hA00, 12'hF00, 12'h400};
        vecs[2] = '{8'h82, 12'hA00, 12'hBFF, 12'h1FF, 12'h800};
        vecs[3] = '{8'h83, 12'hAFF, 12'h5FF, 12'h0FF, 12'hBFF};
        vecs[4] = '{8'h84, 12'h800, 12'h800, 12'h800, 12'h800};
        vecs[5] = '{8'h88, 12'hFFF, 12'h000, 12'h000, 12'hFFF};
        vecs[6] = '{8'h8A, 12'h5FF, 12'h400, 12'hE00, 12'h7FF};
        vecs[7] = '{8'h8B, 12'h500, 12'hA00, 12'hF00, 12'h400};
        vecs[8] = '{8'hCC, 12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF};

        reset       = 1'b1;
        sel_in      = 8'h00;
        phase_inc   = 24'h0;
        sample_tick = 1'b0;

        // Reset state, held independent of the clock.
        #3;
        check_reset_outputs();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle with no valid selection: ticks give midscale.
        step(1'b0, 12'h000, 1'b0, 1'b1);
        step(1'b1, 12'h800, 1'b0, 1'b1);
        check("idle_active_sel", {28'd0, active_sel}, 32'd0);

        // Saw, inc 0x100000, tick every 4 cycles, wrap on the 16th tick.
        start_fresh(8'h81, 24'h100000);
        check("saw_active_sel", {28'd0, active_sel}, 32'h1);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 12'((i + 1) * 256), (i == 15), 1'b1);
            for (int k = 0; k < 3; k++) step(1'b0, 12'h000, 1'b0, 1'b1);
        end
        check("saw_busy", {31'd0, busy_pending}, 32'd0);

        // Table: every wave type / invert combination from a fresh start.
        for (int i = 0; i < 9; i++) begin
            start_fresh(vecs[i].sel, 24'h500000);
            check("vec_active_sel", {28'd0, active_sel}, {28'd0, vecs[i].sel[3], vecs[i].sel[2:0]});
            ex[0] = vecs[i].e1;
            ex[1] = vecs[i].e2;
            ex[2] = vecs[i].e3;
            ex[3] = vecs[i].e4;
            for (int t = 0; t < 4; t++) begin
                step(1'b1, ex[t], (t == 3), 1'b1);
                if (t == 1) begin
                    step(1'b0, 12'h000, 1'b0, 1'b1);
                    check("vec_sample_hold", {20'd0, sample_out}, {20'd0, ex[1]});
                end
            end
        end

        // Disable mid-run, coinciding with a tick: that tick still gives saw.
        start_fresh(8'h81, 24'h100000);
        step(1'b1, 12'h100, 1'b0, 1'b1);
        step(1'b1, 12'h200, 1'b0, 1'b1);
        sel_in = 8'h01;
        step(1'b1, 12'h300, 1'b0, 1'b1);
        step(1'b1, 12'h800, 1'b0, 1'b1);
        step(1'b1, 12'h800, 1'b0, 1'b1);
        sel_in = 8'h85;
        step(1'b1, 12'h800, 1'b0, 1'b1);
        check("idle_busy", {31'd0, busy_pending}, 32'd0);
        sel_in = 8'h81;
        step(1'b0, 12'h000, 1'b0, 1'b1);
        step(1'b1, 12'h100, 1'b0, 1'b1);

        // Pending switch saw -> square, taken at the wrap.
        start_fresh(8'h81, 24'h100000);
        for (int i = 1; i <= 8; i++) step(1'b1, 12'(i * 256), 1'b0, 1'b1);
        sel_in = 8'h80;
        step(1'b0, 12'h000, 1'b0, 1'b1);
        check("pend_busy_set", {31'd0, busy_pending}, 32'd1);
        check("pend_active_kept", {28'd0, active_sel}, 32'h1);
        for (int i = 9; i <= 15; i++) step(1'b1, 12'(i * 256), 1'b0, 1'b1);
        check("pend_busy_held", {31'd0, busy_pending}, 32'd1);
        step(1'b1, 12'h000, 1'b1, 1'b1);
        check("pend_busy_clr", {31'd0, busy_pending}, 32'd0);
        check("pend_active_new", {28'd0, active_sel}, 32'h0);
        for (int k = 1; k <= 8; k++) step(1'b1, (k == 8) ? 12'hFFF : 12'h000, 1'b0, 1'b1);

        // Pending switch withdrawn before the wrap.
        start_fresh(8'h81, 24'h100000);
        step(1'b1, 12'h100, 1'b0, 1'b1);
        step(1'b1, 12'h200, 1'b0, 1'b1);
        sel_in = 8'h83;
        step(1'b0, 12'h000, 1'b0, 1'b1);
        check("cancel_busy_set", {31'd0, busy_pending}, 32'd1);
        step(1'b1, 12'h300, 1'b0, 1'b1);
        sel_in = 8'h81;
        step(1'b0, 12'h000, 1'b0, 1'b1);
        check("cancel_busy_clr", {31'd0, busy_pending}, 32'd0);
        check("cancel_active", {28'd0, active_sel}, 32'h1);
        step(1'b1, 12'h400, 1'b0, 1'b1);

        // Zero increment with a pending change: switch on the next tick.
        start_fresh(8'h81, 24'h100000);
        for (int i = 1; i <= 3; i++) step(1'b1, 12'(i * 256), 1'b0, 1'b1);
        phase_inc = 24'h0;
        sel_in    = 8'h80;
        step(1'b0, 12'h000, 1'b0, 1'b1);
        check("zinc_busy_set", {31'd0, busy_pending}, 32'd1);
        step(1'b1, 12'h000, 1'b0, 1'b0);
        check("zinc_busy_clr", {31'd0, busy_pending}, 32'd0);
        check("zinc_active", {28'd0, active_sel}, 32'h0);
        step(1'b1, 12'h000, 1'b0, 1'b1);
        step(1'b1, 12'h000, 1'b0, 1'b1);

        // Short reset pulse between edges while a switch is pending.
        start_fresh(8'h81, 24'h100000);
        step(1'b1, 12'h100, 1'b0, 1'b1);
        step(1'b1, 12'h200, 1'b0, 1'b1);
        sel_in = 8'h80;
        step(1'b0, 12'h000, 1'b0, 1'b1);
        check("rstp_busy_set", {31'd0, busy_pending}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs();
        #1;
        reset = 1'b0;
        step(1'b0, 12'h000, 1'b0, 1'b1);
        check("rstp_busy", {31'd0, busy_pending}, 32'd0);
        check("rstp_active", {28'd0, active_sel}, 32'h0);
        step(1'b1, 12'h000, 1'b0, 1'b1);

        check("queue_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wave_mux_generator.md
WAVE_MUX_GENERATOR -- requirements
Module: wave_mux_generator

Interface
REQ-001 Parameter ACC_W, default 24, phase accumulator width.
REQ-002 Parameter OUT_W, default 12, sample width; OUT_W SHALL be less than ACC_W.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sel_in  input  8  waveform selector word, driven by the upstream Avalon PIO output port.
  - bit7: enable
  - bit3: invert
  - bits2:0: wave type
  - bits6:4: ignored
REQ-006 phase_inc  input  ACC_W  per-sample phase increment; frequency = f_tick*phase_inc/2^ACC_W.
REQ-007 sample_tick  input  1  one-cycle sample-rate strobe.
REQ-008 sample_out  output  OUT_W  registered waveform sample, unsigned offset-binary.
REQ-009 sample_valid  output  1  one-cycle pulse; sample_out updated this cycle.
REQ-010 active_sel  output  4  {invert, type} currently generating.
REQ-011 wrap  output  1  one-cycle pulse on accumulator carry-out.
REQ-012 busy_pending  output  1  high while a selection change awaits phase wrap.

Function
REQ-013 State machine SHALL have states IDLE, RUN, PENDING.
REQ-014 "valid" SHALL mean sel_in[7]=1 and sel_in[2:0] no greater than 4; otherwise the selection is invalid.
REQ-015 IDLE->RUN on a valid sel_in, with:
  - acc cleared to 0
  - active_sel loaded from {sel_in[3], sel_in[2:0]}
REQ-016 RUN->PENDING when sel_in is valid and {sel_in[3],sel_in[2:0]} differs from active_sel.
REQ-017 PENDING->RUN without reload when sel_in again equals active_sel.
REQ-018 PENDING->RUN on a sample_tick that produces a wrap, or on any sample_tick when phase_inc=0.
  - active_sel SHALL load the current sel_in.
  - acc continues; it is not cleared.
REQ-019 Any state->IDLE on the cycle after an invalid sel_in, with acc cleared; this has priority over all other transitions.
REQ-020 In RUN/PENDING, on sample_tick, acc SHALL become (acc + phase_inc) mod 2^ACC_W.
  - wrap SHALL pulse the next cycle when the addition carries out.
  - acc SHALL hold when there is no tick.
REQ-021 Phase p = acc[ACC_W-1 -: OUT_W]; the post-update value SHALL be used.
  - type 0 square: all-ones if acc MSB=1, else 0.
  - type 1 saw: p.
  - type 2 triangle: acc[ACC_W-2 -: OUT_W] if MSB=0, else its bitwise inverse.
  - type 3 ramp-down: ~p.
  - type 4 DC: midscale 2^(OUT_W-1).
REQ-022 When invert=1, the selected sample SHALL be bitwise inverted before registering.
REQ-023 Latency: sample_out and sample_valid SHALL update exactly one cycle after sample_tick, in every state.
REQ-024 In IDLE, each tick SHALL produce sample_valid with sample_out = midscale (0x800 for OUT_W=12).
REQ-025 A sel_in change coinciding with sample_tick SHALL NOT affect that tick's sample; the selection applies from the next tick at the earliest.
REQ-026 Without sample_tick, sample_out, sample_valid=0 and acc SHALL hold.
REQ-027 busy_pending SHALL equal (state==PENDING), registered.

Reset
REQ-028 While reset is high, the block SHALL be held as follows, independent of clk:
  - state=IDLE
  - acc=0
  - sample_out=midscale
  - sample_valid=0
  - wrap=0
  - active_sel=0
  - busy_pending=0
REQ-029 A reset asserted mid-operation SHALL abort any pending switch; after release, operation SHALL resume from REQ-015 on a valid sel_in.

Verification
REQ-030 sel_in=0x81, phase_inc=0x100000, tick every 4 cycles -> sample_out sequence 0x100,0x200,...,0xF00,0x000; wrap on the 16th tick.
REQ-031 Running saw, at acc=0x800000 set sel_in=0x80 -> busy_pending=1, saw continues until wrap, then square starts at 0x000 with active_sel=0x0.
REQ-032 PENDING, then sel_in restored to the original value before wrap -> busy_pending=0, no glitch, active_sel unchanged.
REQ-033 sel_in=0x01 (enable=0) mid-run -> IDLE next cycle, following ticks give 0x800, acc=0.
REQ-034 phase_inc=0 with a pending change -> switch applied on the next tick, sample_out constant per the new type.
REQ-035 Reset pulsed for 1 ns between clk edges during PENDING -> outputs at reset values immediately, busy_pending=0, no sample_valid until a tick after release.
